// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, idle control pattern and flush.
// Define SKID_EN for the 2-entry skid buffer (registered in_ready); otherwise single-entry.
module pipe_stage_skid #(
    parameter int              CW        = 4,
    parameter int              DW        = 101,
    parameter logic [CW-1:0]   CTRL_IDLE = 4'b0011
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ctrl,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ctrl,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    logic          r_m_valid;
    logic [CW-1:0] r_m_ctrl;
    logic [DW-1:0] r_m_data;
    logic          w_in_fire;
    logic          w_out_fire;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_m_valid & out_ready;
    assign out_valid  = r_m_valid;
    // Only the control field is idled; data keeps its last value.
    assign out_ctrl   = r_m_valid ? r_m_ctrl : CTRL_IDLE;
    assign out_data   = r_m_data;

`ifdef SKID_EN
    logic          r_s_valid;
    logic [CW-1:0] r_s_ctrl;
    logic [DW-1:0] r_s_data;

    // Registered ready: no combinational path from out_ready.
    assign in_ready = !r_s_valid;
    assign occ      = {1'b0, r_m_valid} + {1'b0, r_s_valid};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= CTRL_IDLE;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_ctrl  <= CTRL_IDLE;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid) begin
            if (w_in_fire) begin
                r_m_valid <= 1'b1;
                r_m_ctrl  <= in_ctrl;
                r_m_data  <= in_data;
            end
        end else if (!r_s_valid) begin
            if (w_out_fire) begin
                if (w_in_fire) begin
                    r_m_ctrl <= in_ctrl;
                    r_m_data <= in_data;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_s_valid <= 1'b1;
                r_s_ctrl  <= in_ctrl;
                r_s_data  <= in_data;
            end
        end else if (w_out_fire) begin
            r_m_ctrl  <= r_s_ctrl;
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !r_m_valid | out_ready;
    assign occ      = {1'b0, r_m_valid};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= CTRL_IDLE;
            r_m_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_m_valid <= 1'b1;
            r_m_ctrl  <= in_ctrl;
            r_m_data  <= in_data;
        end else if (w_out_fire) begin
            r_m_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; expectations follow SKID_EN when defined.
module tb_pipe_stage_skid;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_ctrl;
    logic [100:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_ctrl;
    logic [100:0] out_data;
    logic [1:0]   occ;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_skid dut (
        .CLK(CLK), .RSTN(RSTN), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occ(occ)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input int d);
        in_valid = v;
        in_data  = 101'(d);
        in_ctrl  = 4'hC;
    endtask

    task automatic test_reset;
        RSTN = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 0);
        #23;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 4'b0011) begin n_bad++; $display("FAIL rst_out_ctrl got %h want 3", out_ctrl); end
        n_cmp++; if (out_data !== 101'd0) begin n_bad++; $display("FAIL rst_out_data got %0d want 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL rst_occ got %0d want 0", occ); end
        RSTN = 1'b1;
        tick; tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 4'b0011) begin n_bad++; $display("FAIL idle_out_ctrl got %h want 3", out_ctrl); end
        n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL idle_occ got %0d want 0", occ); end
    endtask

    task automatic test_stream;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i);
            tick;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            n_cmp++; if (out_data !== 101'(i)) begin n_bad++; $display("FAIL stream_data[%0d] got %0d want %0d", i, out_data, i); end
            n_cmp++; if (out_ctrl !== 4'hC) begin n_bad++; $display("FAIL stream_ctrl[%0d] got %h want c", i, out_ctrl); end
            n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occ); end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
        end
        drive(1'b0, 0);
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 4'b0011) begin n_bad++; $display("FAIL bubble_ctrl got %h want 3", out_ctrl); end
        n_cmp++; if (out_data !== 101'd8) begin n_bad++; $display("FAIL bubble_data_hold got %0d want 8", out_data); end
        n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL bubble_occ got %0d want 0", occ); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        drive(1'b1, 10);
        tick;
        n_cmp++; if (out_data !== 101'd10) begin n_bad++; $display("FAIL bp_first got %0d want 10", out_data); end
        out_ready = 1'b0;
        drive(1'b1, 11);
`ifdef SKID_EN
        tick;
        n_cmp++; if (occ !== 2'd2) begin n_bad++; $display("FAIL bp_occ2 got %0d want 2", occ); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_data !== 101'd10) begin n_bad++; $display("FAIL bp_hold10 got %0d want 10", out_data); end
        drive(1'b1, 12);
        tick;
        n_cmp++; if (occ !== 2'd2 || out_data !== 101'd10) begin n_bad++; $display("FAIL bp_stall got occ %0d data %0d want 2/10", occ, out_data); end
        out_ready = 1'b1;
        tick;
        n_cmp++; if (out_data !== 101'd11 || occ !== 2'd1) begin n_bad++; $display("FAIL bp_drain11 got data %0d occ %0d want 11/1", out_data, occ); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
        tick;
`else
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ns_ready_low got %b want 0", in_ready); end
        tick;
        n_cmp++; if (occ !== 2'd1 || out_data !== 101'd10) begin n_bad++; $display("FAIL ns_hold got occ %0d data %0d want 1/10", occ, out_data); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ns_ready_comb got %b want 1", in_ready); end
        tick;
        n_cmp++; if (out_data !== 101'd11 || occ !== 2'd1) begin n_bad++; $display("FAIL ns_take11 got data %0d occ %0d want 11/1", out_data, occ); end
        drive(1'b1, 12);
        tick;
`endif
        n_cmp++; if (out_data !== 101'd12 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_last12 got data %0d valid %b want 12/1", out_data, out_valid); end
        drive(1'b0, 0);
        tick;
        n_cmp++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got occ %0d valid %b want 0/0", occ, out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, 20);
        tick;
`ifdef SKID_EN
        drive(1'b1, 21);
        tick;
        n_cmp++; if (occ !== 2'd2) begin n_bad++; $display("FAIL fl_pre_occ got %0d want 2", occ); end
`else
        n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL fl_pre_occ got %0d want 1", occ); end
`endif
        flush = 1'b1;
        drive(1'b1, 22);
        tick;
        flush = 1'b0;
        drive(1'b0, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 4'b0011) begin n_bad++; $display("FAIL fl_ctrl got %h want 3", out_ctrl); end
        n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL fl_occ got %0d want 0", occ); end
        n_cmp++; if (out_data !== 101'd20) begin n_bad++; $display("FAIL fl_data_kept got %0d want 20", out_data); end
        out_ready = 1'b1;
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_no_ghost got %b want 0", out_valid); end
        // Beat offered into an empty stage during flush must be dropped.
        flush = 1'b1;
        drive(1'b1, 23);
        tick;
        flush = 1'b0;
        drive(1'b0, 0);
        n_cmp++; if (out_valid !== 1'b0 || occ !== 2'd0) begin n_bad++; $display("FAIL fl_drop_in got valid %b occ %0d want 0/0", out_valid, occ); end
        tick;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(1'b1, 30);
        tick;
        drive(1'b1, 31);
        tick;
        drive(1'b0, 0);
        #2;
        RSTN = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got %b want 0", out_valid); end
        n_cmp++; if (out_ctrl !== 4'b0011) begin n_bad++; $display("FAIL ar_ctrl got %h want 3", out_ctrl); end
        n_cmp++; if (out_data !== 101'd0) begin n_bad++; $display("FAIL ar_data got %0d want 0", out_data); end
        n_cmp++; if (occ !== 2'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ar_occ_ready got occ %0d rdy %b want 0/1", occ, in_ready); end
        #3;
        RSTN = 1'b1;
        tick;
        out_ready = 1'b1;
        drive(1'b1, 40);
        tick;
        drive(1'b0, 0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 101'd40) begin n_bad++; $display("FAIL ar_recover got valid %b data %0d want 1/40", out_valid, out_data); end
        tick;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_flush;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
